// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Drives one shared hex decoder, adds dead-time blanking, decimal points and leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [3:0]              hex_out,
    input  logic [7:0]              seg_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_val, pend_val;
    logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
    logic                    pend_flag;
    logic                    en_q;

    logic                    slot_end, frame_end, xfer;
    logic                    cur_dp, cur_blank, zero_above;
    logic [NUM_DIGITS-1:0]   an_act;

    assign slot_end  = enable && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    // The first enabled cycle after a dark period acts as a frame boundary for pending data.
    assign xfer      = frame_end || (enable && !en_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= enable;
            if (!enable) begin
                cnt <= '0;
                idx <= '0;
            end else if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_flag  <= 1'b0;
        end else if (load) begin
            if (xfer) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
                pend_flag  <= 1'b0;
            end else begin
                pend_val  <= value_in;
                pend_dp   <= dp_in;
                pend_flag <= 1'b1;
            end
        end else if (xfer && pend_flag) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
            pend_flag  <= 1'b0;
        end
    end

    // NOTE: zero_above is a blocking running accumulator; every output gets a default first so no latch forms.
    always_comb begin
        hex_out    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        an_act     = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shadow_val[i*4 +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                hex_out   = shadow_val[i*4 +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = lz_blank && (i != 0) && zero_above;
                an_act[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (!enable || cnt < CNT_BLANK) begin
                seg_out <= 8'hFF;
                an_out  <= '1;
            end else begin
                an_out  <= an_act;
                seg_out <= {~cur_dp, cur_blank ? 7'h7F : seg_in[6:0]};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of per-frame display expectations plus reset/enable sequences.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [15:0]  value_in;
    logic [3:0]   dp_in;
    logic         lz_blank;
    logic         load;
    logic [3:0]   hex_out;
    logic [7:0]   seg_in;
    logic [7:0]   seg_out;
    logic [3:0]   an_out;
    logic         frame_tick;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  blank;   // hand-computed leading-zero blank mask
        int          decoy;   // cycle to load 16'hAAAA (overwritten later), -1 none
        int          ld;      // cycle to load the next row, -1 none
    } row_t;

    row_t rows[6];

    seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
        .lz_blank(lz_blank), .load(load), .hex_out(hex_out), .seg_in(seg_in),
        .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: dec7 = 7'h40; 4'h1: dec7 = 7'h79; 4'h2: dec7 = 7'h24; 4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19; 4'h5: dec7 = 7'h12; 4'h6: dec7 = 7'h02; 4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00; 4'h9: dec7 = 7'h10; 4'hA: dec7 = 7'h08; 4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46; 4'hD: dec7 = 7'h21; 4'hE: dec7 = 7'h06; default: dec7 = 7'h0E;
        endcase
    endfunction

    // External decoder; bit7 deliberately low so seg_out[7] must come from the dp register.
    assign seg_in = {1'b0, dec7(hex_out)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic check_dark(input string tag);
        check({tag, " an"}, 32'(an_out), 32'hF);
        check({tag, " seg"}, 32'(seg_out), 32'hFF);
        check({tag, " tick"}, 32'(frame_tick), 32'h0);
    endtask

    // Entered at the negedge of the frame's first enabled cycle; leaves at the next frame's first negedge.
    task automatic run_frame(input row_t r, input row_t nxt, input bit init_load, input string tag);
        logic [15:0] v;
        logic [3:0]  nib, exp_an;
        logic [7:0]  exp_seg;
        int          d, p;
        v = r.val;
        for (int c = 0; c < FRAME; c++) begin
            d = c / DIV;
            p = c % DIV;
            enable   = 1'b1;
            lz_blank = r.lz;
            load     = 1'b0;
            if (c == 0 && init_load) begin
                load = 1'b1; value_in = r.val; dp_in = r.dp;
            end else if (c == r.decoy) begin
                load = 1'b1; value_in = 16'hAAAA; dp_in = 4'hF;
            end else if (c == r.ld) begin
                load = 1'b1; value_in = nxt.val; dp_in = nxt.dp;
            end
            nib = v[d*4 +: 4];
            if (p >= BLANK) check($sformatf("%s hex d%0d p%0d", tag, d, p), 32'(hex_out), 32'(nib));
            @(posedge clk);
            #1;
            if (p < BLANK) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an    = 4'hF;
                exp_an[d] = 1'b0;
                exp_seg   = {~r.dp[d], r.blank[d] ? 7'h7F : dec7(nib)};
            end
            check($sformatf("%s an d%0d p%0d", tag, d, p), 32'(an_out), 32'(exp_an));
            check($sformatf("%s seg d%0d p%0d", tag, d, p), 32'(seg_out), 32'(exp_seg));
            check($sformatf("%s tick c%0d", tag, c), 32'(frame_tick), (c == FRAME - 1) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    row_t late, zero_row;

    initial begin
        rows[0] = '{16'h1234, 4'b0000, 1'b0, 4'b0000, -1, 31};
        rows[1] = '{16'h0050, 4'b0000, 1'b1, 4'b1100,  5,  7};
        rows[2] = '{16'h0000, 4'b0100, 1'b1, 4'b1110, -1, 31};
        rows[3] = '{16'h0A00, 4'b1001, 1'b1, 4'b1000, 10, 20};
        rows[4] = '{16'h8001, 4'b0000, 1'b1, 4'b0000, -1,  0};
        rows[5] = '{16'h0050, 4'b0010, 1'b0, 4'b0000, -1, -1};
        late     = '{16'h0007, 4'b0001, 1'b1, 4'b1110, -1, -1};
        zero_row = '{16'h0000, 4'b0000, 1'b0, 4'b0000, -1, -1};

        reset = 1'b1; enable = 1'b0; load = 1'b0; lz_blank = 1'b0;
        value_in = '0; dp_in = '0;
        repeat (3) @(posedge clk);
        #1 check_dark("reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 check_dark($sformatf("idle%0d", i));
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++)
            run_frame(rows[i], rows[(i < 5) ? i + 1 : i], i == 0, $sformatf("row%0d", i));

        // Dark period with a pending load; it must appear as soon as scanning resumes.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                load = 1'b1; value_in = late.val; dp_in = late.dp;
            end
            @(posedge clk);
            #1 check_dark($sformatf("off%0d", i));
            @(negedge clk);
            load = 1'b0;
        end
        run_frame(late, late, 1'b0, "reen");

        // Advance into digit2's active phase, then assert reset between edges.
        for (int i = 0; i < 2 * DIV + 4; i++) @(negedge clk);
        check("pre-reset an", 32'(an_out), 32'hB);
        #2 reset = 1'b1;
        #1 check_dark("async");
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        run_frame(zero_row, zero_row, 1'b0, "postrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
